// File: rtl/dcache_responder_if.sv
// rtl/dcache_responder_if.sv - CPU-side request/response and line-wide physical memory signals
interface dcache_responder_if #(
    parameter int S_OFFSET = 5
);
    localparam int LINE_W = 8 * (2 ** S_OFFSET);

    logic [31:0]       mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_mbe;
    logic [31:0]       mem_rdata;
    logic              mem_resp;
    logic [31:0]       pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_wdata, mem_mbe,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_wdata, mem_mbe,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - direct-mapped write-back cache responder; DCACHE_STATS_EN adds hit/miss/writeback counters
module dcache_responder #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3
) (
    input  logic                clk,
    input  logic                rst,
    dcache_responder_if.slave   bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count,
    output logic [31:0]         writeback_count
`endif
);
    localparam int LINE_W = 8 * (2 ** S_OFFSET);
    localparam int SETS   = 2 ** S_INDEX;
    localparam int TAG_W  = 32 - S_OFFSET - S_INDEX;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t              state_q, state_d;
    logic [SETS-1:0]     valid_q, valid_d;
    logic [SETS-1:0]     dirty_q, dirty_d;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [TAG_W-1:0]    tag_d  [SETS];
    logic [LINE_W-1:0]   data_q [SETS];
    logic [LINE_W-1:0]   data_d [SETS];

    logic [TAG_W-1:0]    req_tag;
    logic [S_INDEX-1:0]  idx;
    logic [S_OFFSET-3:0] word;
    logic                req;
    logic                hit;
    logic                unused_addr_bits;

    assign req_tag          = bus.mem_address[31:S_OFFSET+S_INDEX];
    assign idx              = bus.mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign word             = bus.mem_address[S_OFFSET-1:2];
    assign req              = bus.mem_read | bus.mem_write;
    assign hit              = valid_q[idx] && (tag_q[idx] == req_tag);
    assign unused_addr_bits = ^bus.mem_address[1:0];

    always_comb begin
        state_d          = state_q;
        valid_d          = valid_q;
        dirty_d          = dirty_q;
        tag_d            = tag_q;
        data_d           = data_q;
        bus.mem_rdata    = '0;
        bus.mem_resp     = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        bus.mem_resp = 1'b1;
                        // A simultaneous read+write is serviced purely as a write.
                        if (bus.mem_write) begin
                            for (int b = 0; b < 4; b++) begin
                                if (bus.mem_mbe[b])
                                    data_d[idx][{word, b[1:0], 3'b000} +: 8] = bus.mem_wdata[8*b +: 8];
                            end
                            dirty_d[idx] = 1'b1;
                        end else begin
                            bus.mem_rdata = data_q[idx][{word, 5'b00000} +: 32];
                        end
                    end else if (valid_q[idx] && dirty_q[idx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[idx], idx, {S_OFFSET{1'b0}}};
                bus.pmem_wdata   = data_q[idx];
                if (bus.pmem_resp) begin
                    dirty_d[idx] = 1'b0;
                    state_d      = FILL;
                end
            end
            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {req_tag, idx, {S_OFFSET{1'b0}}};
                if (bus.pmem_resp) begin
                    data_d[idx]  = bus.pmem_rdata;
                    tag_d[idx]   = req_tag;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone decide their meaning.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        miss_seen_q, miss_seen_d;
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic [31:0] wb_count_q, wb_count_d;
    logic        hit_inc, miss_inc, wb_inc;

    assign hit_inc  = (state_q == IDLE) && req && hit && !miss_seen_q;
    assign miss_inc = (state_q == IDLE) && req && !hit;
    assign wb_inc   = (state_q == WRITEBACK) && bus.pmem_resp;

    always_comb begin
        miss_seen_d  = miss_seen_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;
        if (miss_inc)
            miss_seen_d = 1'b1;
        else if (bus.mem_resp)
            miss_seen_d = 1'b0;
        if (hit_inc && (hit_count_q != 32'hFFFF_FFFF))
            hit_count_d = hit_count_q + 32'd1;
        if (miss_inc && (miss_count_q != 32'hFFFF_FFFF))
            miss_count_d = miss_count_q + 32'd1;
        if (wb_inc && (wb_count_q != 32'hFFFF_FFFF))
            wb_count_d = wb_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_seen_q  <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            miss_seen_q  <= miss_seen_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign hit_count       = hit_count_q;
    assign miss_count      = miss_count_q;
    assign writeback_count = wb_count_q;
`endif
endmodule
